shift_even_norm_seq: RTL and testbench

// - Sequential, parametrised even-bit left normaliser for the fsqrt mantissa path.
// - Shifts the operand left by an even amount until the top two bits are 1x or 01.
// - Resolves one shift level per cycle, with valid/ready handshakes on both sides.
// - Sits between operand unpack and the square-root iteration datapath.
// - Replaces the fixed 24-bit combinational even-shifter: any width, zero-filled shifts, flow control.
//

---
 rtl/shift_even_norm_seq.sv | 168 ++++++++++++++++
 tb/tb_shift_even_norm_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_even_norm_seq.sv
// ---------------------------------------------------------------------------
// shift_even_norm_seq
//   Sequential even-bit left normaliser for the fsqrt mantissa path. An
//   accepted operand is shifted left by an even amount until its top two bits
//   are 1x or 01. One shift level (2^K down to 2^1) is resolved per cycle.
//
//   Optional feature macro: NORM_ZERO_DET_EN
//     defined   : an all-zero operand reports out_zero=1 and out_sa=0
//     undefined : out_zero is tied 0; a zero operand reports out_sa=2^(K+1)-2
//
// Parameters
//   W    operand width (even, >= 4)
//   SAW  shift-amount width (holds the sum of all level shifts)
//
// Ports
//   clk        in   rising-edge clock
//   clrn       in   asynchronous active-low reset
//   in_valid   in   operand valid
//   in_ready   out  operand can be accepted this cycle
//   in_data    in   operand to normalise [W]
//   out_valid  out  result valid, held until consumed
//   out_ready  in   downstream accepts result
//   out_data   out  normalised operand [W]
//   out_sa     out  applied left-shift amount, always even [SAW]
//   out_zero   out  operand was all-zero (feature build only)
// ---------------------------------------------------------------------------
module shift_even_norm_seq #(
  parameter int W   = 24,
  parameter int SAW = $clog2(W) + 1
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [SAW-1:0] out_sa,
  output logic           out_zero
);

  // Largest k with 2^k < W.
  localparam int K = $clog2(W) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e         state_q;
  logic [W-1:0]   work_q;
  logic [SAW-1:0] sa_q;
  logic [SAW-1:0] level_q;
  logic           out_valid_q;
  logic [W-1:0]   out_data_q;
  logic [SAW-1:0] out_sa_q;
`ifdef NORM_ZERO_DET_EN
  logic           zero_q;
  logic           out_zero_q;
`endif

  logic [SAW-1:0] shamt_s;
  logic [W-1:0]   top_mask_s;
  logic [W-1:0]   work_d;
  logic [SAW-1:0] sa_d;
  logic           in_ready_s;
  logic           accept_s;

  // Handshake: ready in IDLE (not while reset is asserted), or in DONE when
  // the current result is consumed on the same edge.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      IDLE:    in_ready_s = clrn;
      DONE:    in_ready_s = clrn & out_ready;
      default: in_ready_s = 1'b0;
    endcase
    accept_s = in_valid & in_ready_s;
  end

  // One shift level: shift by s=2^level only if the top s bits are all zero.
  always_comb begin
    shamt_s    = {{(SAW-1){1'b0}}, 1'b1} << level_q;
    top_mask_s = ~({W{1'b1}} >> shamt_s);
    if ((work_q & top_mask_s) == {W{1'b0}}) begin
      work_d = work_q << shamt_s;
      sa_d   = sa_q + shamt_s;
    end else begin
      work_d = work_q;
      sa_d   = sa_q;
    end
  end

  // Control FSM plus work/result registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      work_q      <= {W{1'b0}};
      sa_q        <= {SAW{1'b0}};
      level_q     <= {SAW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {W{1'b0}};
      out_sa_q    <= {SAW{1'b0}};
`ifdef NORM_ZERO_DET_EN
      zero_q      <= 1'b0;
      out_zero_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        SHIFT: begin
          work_q  <= work_d;
          sa_q    <= sa_d;
          level_q <= level_q - {{(SAW-1){1'b0}}, 1'b1};
          // The last level's result is published directly on the edge
          // that enters DONE.
          if (level_q == {{(SAW-1){1'b0}}, 1'b1}) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= work_d;
`ifdef NORM_ZERO_DET_EN
            out_sa_q    <= zero_q ? {SAW{1'b0}} : sa_d;
            out_zero_q  <= zero_q;
`else
            out_sa_q    <= sa_d;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
      // Accept overrides the IDLE/DONE transition above, so a consume and a
      // new load can share one edge.
      if (accept_s) begin
        state_q <= SHIFT;
        work_q  <= in_data;
        sa_q    <= {SAW{1'b0}};
        level_q <= SAW'(K);
`ifdef NORM_ZERO_DET_EN
        zero_q  <= ~|in_data;
`endif
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sa    = out_sa_q;
`ifdef NORM_ZERO_DET_EN
  assign out_zero  = out_zero_q;
`else
  assign out_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_shift_even_norm_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_even_norm_seq
//   Self-checking bench for shift_even_norm_seq at W=24. A reference model
//   derives each expected result from the operand's leading-zero count; a
//   negedge monitor compares every valid output against it. Directed cases
//   also check hand-computed literals, latency, stalls and mid-flight reset.
// ---------------------------------------------------------------------------
module tb_shift_even_norm_seq;

  localparam int W   = 24;
  localparam int SAW = 6;

  typedef struct {
    logic [W-1:0]   data;
    logic [SAW-1:0] sa;
    logic           zero;
  } exp_t;

  logic           clk;
  logic           clrn;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [SAW-1:0] out_sa;
  logic           out_zero;

  int checks;
  int errors;
  exp_t exp_q[$];

  shift_even_norm_seq #(.W(W), .SAW(SAW)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sa    (out_sa),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shift = leading-zero count rounded down to even.
  function automatic exp_t model(input logic [W-1:0] d);
    exp_t e;
    int lz;
    lz = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (d[i] && lz == W) lz = W - 1 - i;
    end
    if (d == '0) begin
      e.data = '0;
`ifdef NORM_ZERO_DET_EN
      e.sa   = 6'd0;
      e.zero = 1'b1;
`else
      e.sa   = 6'd30;
      e.zero = 1'b0;
`endif
    end else begin
      e.sa   = SAW'(lz - (lz % 2));
      e.data = d << e.sa;
      e.zero = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare each valid output with the oldest outstanding operand.
  always @(negedge clk) begin
    if (!clrn) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stale_valid: got out_valid=1 with data %0h, expected no result", out_data);
        end else if (out_data !== exp_q[0].data || out_sa !== exp_q[0].sa ||
                     out_zero !== exp_q[0].zero) begin
          errors++;
          $display("FAIL monitor: got data=%0h sa=%0d zero=%0b, expected data=%0h sa=%0d zero=%0b",
                   out_data, out_sa, out_zero, exp_q[0].data, exp_q[0].sa, exp_q[0].zero);
        end else if (!exp_q[0].zero && exp_q[0].data != '0) begin
          checks++;
          if (out_data[W-1:W-2] == 2'b00) begin
            errors++;
            $display("FAIL top_bits: got %0b, expected nonzero", out_data[W-1:W-2]);
          end
        end
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
    end
  end

  task automatic send(input logic [W-1:0] d);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0, expected 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Returns the number of edges counted from the accept edge (inclusive)
  // until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
  endtask

  task automatic run_one(input logic [W-1:0] d, input logic [W-1:0] xd, input logic [SAW-1:0] xs);
    int n;
    send(d);
    wait_valid(n);
    check("latency", 32'(n), 32'd5);
    check("lit_data", 32'(out_data), 32'(xd));
    check("lit_sa", 32'(out_sa), 32'(xs));
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    exp_t  e;
    int    n;
    logic [W-1:0] r;
    checks    = 0;
    errors    = 0;
    clrn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Model pinned against hand-computed values.
    e = model(24'h000001); check("model_1_sa", 32'(e.sa), 32'd22);
    check("model_1_data", 32'(e.data), 32'h400000);
    e = model(24'h200000); check("model_2_sa", 32'(e.sa), 32'd2);
    e = model(24'h012345); check("model_3_data", 32'(e.data), 32'h48D140);

    // Reset state.
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sa", 32'(out_sa), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1 check("idle_in_ready", 32'(in_ready), 32'd1);

    // Directed operands.
    run_one(24'h000001, 24'h400000, 6'd22);
    run_one(24'h800000, 24'h800000, 6'd0);
    run_one(24'h200000, 24'h800000, 6'd2);
    run_one(24'h00ABCD, 24'hABCD00, 6'd8);
    run_one(24'h012345, 24'h48D140, 6'd6);
    run_one(24'h7FFFFF, 24'h7FFFFF, 6'd0);
`ifdef NORM_ZERO_DET_EN
    run_one(24'h000000, 24'h000000, 6'd0);
    check("zero_flag", 32'(out_zero), 32'd1);
`else
    run_one(24'h000000, 24'h000000, 6'd30);
    check("zero_flag", 32'(out_zero), 32'd0);
`endif

    // Stall in DONE for 10 cycles, then consume and accept on one edge.
    out_ready = 1'b0;
    send(24'h000100);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_data", 32'(out_data), 32'h400000);
      check("hold_sa", 32'(out_sa), 32'd14);
      @(negedge clk);
    end
    in_data   = 24'h0F0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("b2b_consumed", 32'(out_valid), 32'd0);
    check("shift_in_ready", 32'(in_ready), 32'd0);
    wait_valid(n);
    check("b2b_latency", 32'(n), 32'd5);
    check("b2b_data", 32'(out_data), 32'hF00000);
    check("b2b_sa", 32'(out_sa), 32'd4);
    @(posedge clk);
    #1;

    // Reset pulse in SHIFT discards the operand.
    send(24'h000003);
    @(negedge clk);
    #2 clrn = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_sa", 32'(out_sa), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 clrn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_stale", 32'(out_valid), 32'd0);
    end
    run_one(24'h000003, 24'hC00000, 6'd22);

    // Back-to-back sweep checked by the monitor.
    for (int i = 0; i < 24; i++) begin
      r = W'($urandom) >> (i % 24);
      send(r);
    end
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
